// File: rtl/param_decoder.sv
// param_decoder: registered one-hot address decoder with hold, plus an optional auto-scan walk.
// The scan port, SCAN state and dwell counter exist only when PARAM_DECODER_SCAN_EN is defined.
module param_decoder #(
  parameter int ADDR_W = 2,
  parameter int DWELL  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [ADDR_W-1:0]    addr,
  input  logic                 addr_valid,
  output logic                 addr_ready,
`ifdef PARAM_DECODER_SCAN_EN
  input  logic                 scan,
`endif
  output logic [2**ADDR_W-1:0] out,
  output logic                 out_valid,
  output logic [ADDR_W-1:0]    scan_idx
);
  localparam int OUT_W = 2**ADDR_W;
  if (ADDR_W < 1 || ADDR_W > 6 || DWELL < 1 || DWELL > 255) begin : g_bad_param
    $error("param_decoder: ADDR_W or DWELL out of range");
  end
  typedef enum logic [1:0] {
    IDLE,
    HOLD
`ifdef PARAM_DECODER_SCAN_EN
    , SCAN
`endif
  } state_t;
  state_t             r_state;
  logic [OUT_W-1:0]   r_out;
  logic [ADDR_W-1:0]  r_idx;
`ifdef PARAM_DECODER_SCAN_EN
  logic [7:0]         r_cnt;
  assign addr_ready = enable && r_state != SCAN && !scan;
`else
  assign addr_ready = enable;
`endif
  assign out       = r_out;
  assign scan_idx  = r_idx;
  // out is nonzero in exactly the non-IDLE states
  assign out_valid = r_state != IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_out   <= '0;
      r_idx   <= '0;
`ifdef PARAM_DECODER_SCAN_EN
      r_cnt   <= '0;
`endif
    end else if (!enable) begin
      r_state <= IDLE;
      r_out   <= '0;
      r_idx   <= '0;
`ifdef PARAM_DECODER_SCAN_EN
      r_cnt   <= '0;
`endif
    end
`ifdef PARAM_DECODER_SCAN_EN
    else if (scan) begin
      if (r_state != SCAN) begin
        r_state <= SCAN;
        r_out   <= OUT_W'(1);
        r_idx   <= '0;
        r_cnt   <= '0;
      end else if (r_cnt == 8'(DWELL - 1)) begin
        r_cnt   <= '0;
        r_idx   <= r_idx + 1'b1;
        r_out   <= {r_out[OUT_W-2:0], r_out[OUT_W-1]};
      end else begin
        r_cnt   <= r_cnt + 1'b1;
      end
    end else if (r_state == SCAN) begin
      r_state <= IDLE;
      r_out   <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
    end
`endif
    else if (addr_valid) begin
      r_state <= HOLD;
      r_out   <= OUT_W'(1) << addr;
      r_idx   <= addr;
    end
  end
endmodule

// File: doc/param_decoder.md
PARAM_DECODER -- requirements
Module: param_decoder

Interface
REQ-001 SHALL have parameter ADDR_W, default 2, address width in bits; legal range 1..6.
REQ-002 SHALL have parameter DWELL, default 4, cycles each output is held per scan step; legal range 1..255.
REQ-003 SHALL derive localparam OUT_W = 2**ADDR_W as the output vector width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port enable  input  1  global enable; when low, all outputs are forced to zero.
REQ-007 SHALL have port addr  input  ADDR_W  address to decode.
REQ-008 SHALL have port addr_valid  input  1  addr is valid this cycle.
REQ-009 SHALL have port addr_ready  output  1  block accepts addr this cycle.
REQ-010 SHALL have port scan  input  1  scan-mode request (present only with SCAN_EN; see REQ-027).
REQ-011 SHALL have port out  output  OUT_W  registered one-hot decode result.
REQ-012 SHALL have port out_valid  output  1  high when out holds a nonzero one-hot value.
REQ-013 SHALL have port scan_idx  output  ADDR_W  index of the currently asserted out bit; 0 when out is zero.

Function
REQ-014 SHALL implement FSM states IDLE (out zero), HOLD (decoded value held) and SCAN (auto-walk).
REQ-015 SHALL accept an address when addr_valid, addr_ready and enable are all 1 at a rising edge; out = 1<<addr, out_valid = 1, scan_idx = addr, and the FSM enters HOLD on that edge (latency 1 cycle).
REQ-016 SHALL drive addr_ready = enable AND (state != SCAN) AND NOT (scan AND enable), combinationally from the registered state and inputs.
REQ-017 SHALL keep out constant in HOLD until a new address is accepted, which replaces out on the accepting edge with no intermediate zero cycle.
REQ-018 SHALL guarantee out is always either all-zero or exactly one-hot; no other value is ever driven.
REQ-019 SHALL, when enable is sampled low, clear out, out_valid, scan_idx and the dwell counter, and set the FSM to IDLE on that edge; addr_valid is ignored while enable is low.
REQ-020 SHALL, in SCAN entered from any state, set out = 1 (bit 0) on the entry edge, then advance one bit every DWELL cycles, wrapping from bit OUT_W-1 to bit 0.
REQ-021 SHALL use a dwell counter that resets to 0 on each step; advance occurs when the counter equals DWELL-1 (with DWELL=1, advance every cycle).
REQ-022 SHALL give scan priority when scan and addr_valid are both high: the address is not accepted (addr_ready = 0).
REQ-023 SHALL, when scan is sampled low while in SCAN, clear out to zero and enter IDLE on the next edge; it SHALL NOT resume HOLD.
REQ-024 SHALL not change out on an addr_valid pulse with addr_ready low; the address is dropped and the source keeps addr_valid high to retry.

Reset
REQ-025 SHALL, on rst_n low, immediately (asynchronously) set out = 0, out_valid = 0, scan_idx = 0, dwell counter = 0 and FSM = IDLE, independent of clk.
REQ-026 SHALL resume normal operation on the first rising edge after rst_n is deasserted; reset asserted mid-scan or mid-hold loses all state.

Configuration
REQ-027 SHALL compile the scan feature only when macro PARAM_DECODER_SCAN_EN is defined: the scan port, SCAN state and dwell counter are present and REQ-020..REQ-023 apply.
REQ-028 SHALL, without PARAM_DECODER_SCAN_EN, omit the scan port, SCAN state and dwell counter; addr_ready = enable, and behaviour reduces to registered decode with hold (REQ-015..REQ-019, REQ-024); parameter DWELL is accepted but unused.

Verification (ADDR_W=2, DWELL=4, macro defined unless stated)
REQ-029 SHALL cover: enable=0, addr=0..3 pulsed valid -> out=0000, out_valid=0 every cycle; then enable=1, addr=0,1,2,3 -> out=0001,0010,0100,1000, each one cycle after acceptance.
REQ-030 SHALL cover: accept addr=2, then idle 10 cycles with addr_valid=0 -> out stays 0100; accept addr=1 -> out goes 0100 to 0010 with no zero cycle.
REQ-031 SHALL cover: scan=1 for 20 cycles -> out =0001 x4, 0010 x4, 0100 x4, 1000 x4, then 0001 again (wrap); addr_ready=0 throughout; addr_valid with addr=3 is ignored.
REQ-032 SHALL cover: mid-scan at out=0100, drop enable -> out=0000 and state IDLE next edge; re-raise enable with scan=1 -> restart at 0001.
REQ-033 SHALL cover: assert rst_n=0 between clock edges during HOLD of 1000 -> out=0000 before the next edge; after release, accept addr=3 -> 1000.
REQ-034 SHALL cover: macro undefined, ADDR_W=3 -> addr 0..7 decode to the eight one-hot values; addr_ready equals enable.
